hamdec_secded_pipe: RTL and testbench

Parametrised, pipelined SECDED (single-error-correct, double-error-detect) Hamming decoder. It succeeds the fixed 8-bit combinational decoder. Adds generic data width, an overall-parity bit for double-error detection, a valid/ready handshake with backpressure, and saturating error statistics. It sits between the UART receive path / memory read port and the executor command consumer.

---
 rtl/hamdec_secded_pipe_if.sv | 46 ++++
 rtl/hamdec_secded_pipe.sv | 165 ++++++++++++++++
 tb/tb_hamdec_secded_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hamdec_secded_pipe_if.sv
// Handshake/data bundle for the pipelined SECDED decoder.
// The slave modport is the decoder side; master is the upstream/downstream driver side.
interface hamdec_secded_pipe_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
);
   // Smallest P with 2^P >= DATA_WIDTH+P+1 (monotonic, so the last true k wins)
   function automatic int calc_p(input int dw);
      int p;
      p = 1;
      for (int k = 1; k <= 7; k++) begin
         if ((1 << k) < dw + k + 1) p = k + 1;
      end
      return p;
   endfunction

   localparam int P         = calc_p(DATA_WIDTH);
   localparam int EDC_WIDTH = P + 1;

   logic [DATA_WIDTH-1:0]  data_in;
   logic [EDC_WIDTH-1:0]   edc_in;
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_WIDTH-1:0]  data_out;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_corrected;
   logic                   out_uncorrectable;
   logic [P-1:0]           out_syndrome;
   logic [COUNT_WIDTH-1:0] cnt_corrected;
   logic [COUNT_WIDTH-1:0] cnt_uncorrectable;
   logic                   err_sticky;
   logic                   cnt_clear;

   modport slave (
      input  data_in, edc_in, in_valid, out_ready, cnt_clear,
      output in_ready, data_out, out_valid, out_corrected, out_uncorrectable,
             out_syndrome, cnt_corrected, cnt_uncorrectable, err_sticky
   );

   modport master (
      output data_in, edc_in, in_valid, out_ready, cnt_clear,
      input  in_ready, data_out, out_valid, out_corrected, out_uncorrectable,
             out_syndrome, cnt_corrected, cnt_uncorrectable, err_sticky
   );
endinterface

// File: rtl/hamdec_secded_pipe.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready backpressure
// and saturating error statistics. Stage 1 holds data/syndrome/parity,
// stage 2 holds the corrected word and its classification flags.
module hamdec_secded_pipe #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input logic                clk,
   input logic                reset,
   hamdec_secded_pipe_if.slave bus
);
   function automatic int calc_p(input int dw);
      int p;
      p = 1;
      for (int k = 1; k <= 7; k++) begin
         if ((1 << k) < dw + k + 1) p = k + 1;
      end
      return p;
   endfunction

   // Codeword position of data bit idx: the idx-th non-power-of-two position
   function automatic int data_pos(input int idx);
      int result;
      int cnt;
      result = 0;
      cnt    = 0;
      for (int pos = 1; pos < 128; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (cnt == idx) result = pos;
            cnt++;
         end
      end
      return result;
   endfunction

   localparam int           P   = calc_p(DATA_WIDTH);
   localparam int           N   = DATA_WIDTH + P;
   localparam logic [P-1:0] N_P = P'(N);

   logic [P-1:0]          data_term [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] flip_mask;
   logic [P-1:0]          syn_d;
   logic                  par_d;
   logic                  adv;
   logic                  hs;

   logic                  s1_valid_q;
   logic [DATA_WIDTH-1:0] s1_data_q;
   logic [P-1:0]          s1_syn_q;
   logic                  s1_par_q;

   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [P-1:0]          syn_out_q, syn_out_d;
   logic                  corr_q, corr_d;
   logic                  unc_q, unc_d;

   logic [COUNT_WIDTH-1:0] cnt_corr_q, cnt_corr_d;
   logic [COUNT_WIDTH-1:0] cnt_unc_q, cnt_unc_d;
   logic                   sticky_q, sticky_d;

   // Per data bit: syndrome contribution and correction select
   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
         localparam logic [P-1:0] POS = P'(data_pos(gi));
         assign data_term[gi] = bus.data_in[gi] ? POS : '0;
         assign flip_mask[gi] = (s1_syn_q == POS);
      end
   endgenerate

   assign adv          = !out_valid_q || bus.out_ready;
   assign hs           = out_valid_q && bus.out_ready;
   assign bus.in_ready = adv;

   // Syndrome and overall parity of the incoming word; check bit k sits at 2^k so it maps to syndrome bit k
   always_comb begin
      syn_d = bus.edc_in[P-1:0];
      for (int i = 0; i < DATA_WIDTH; i++) syn_d = syn_d ^ data_term[i];
      par_d = (^bus.data_in) ^ (^bus.edc_in);
   end

   // Stage 1 register: captures raw word, syndrome and parity when the pipe advances
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_syn_q   <= '0;
         s1_par_q   <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= bus.in_valid;
         s1_data_q  <= bus.data_in;
         s1_syn_q   <= syn_d;
         s1_par_q   <= par_d;
      end
   end

   // Classification and correction; odd parity with in-range syndrome is correctable (syndrome 0 = parity bit)
   always_comb begin
      logic correctable;
      correctable = s1_par_q && (s1_syn_q <= N_P);
      corr_d      = s1_valid_q && correctable;
      unc_d       = s1_valid_q && !correctable && ((s1_syn_q != '0) || s1_par_q);
      data_out_d  = '0;
      syn_out_d   = '0;
      if (s1_valid_q) begin
         data_out_d = correctable ? (s1_data_q ^ flip_mask) : s1_data_q;
         syn_out_d  = s1_syn_q;
      end
   end

   // Stage 2 register: output word and flags, held while stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         syn_out_q   <= '0;
         corr_q      <= 1'b0;
         unc_q       <= 1'b0;
      end else if (adv) begin
         out_valid_q <= s1_valid_q;
         data_out_q  <= data_out_d;
         syn_out_q   <= syn_out_d;
         corr_q      <= corr_d;
         unc_q       <= unc_d;
      end
   end

   // Saturating statistics on output handshakes; clear overrides a same-cycle increment
   always_comb begin
      cnt_corr_d = cnt_corr_q;
      cnt_unc_d  = cnt_unc_q;
      sticky_d   = sticky_q;
      if (bus.cnt_clear) begin
         cnt_corr_d = '0;
         cnt_unc_d  = '0;
         sticky_d   = 1'b0;
      end else if (hs) begin
         if (corr_q && (cnt_corr_q != '1)) cnt_corr_d = cnt_corr_q + 1'b1;
         if (unc_q && (cnt_unc_q != '1))   cnt_unc_d  = cnt_unc_q + 1'b1;
         if (corr_q || unc_q)              sticky_d   = 1'b1;
      end
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_corr_q <= '0;
         cnt_unc_q  <= '0;
         sticky_q   <= 1'b0;
      end else begin
         cnt_corr_q <= cnt_corr_d;
         cnt_unc_q  <= cnt_unc_d;
         sticky_q   <= sticky_d;
      end
   end

   assign bus.out_valid         = out_valid_q;
   assign bus.data_out          = data_out_q;
   assign bus.out_syndrome      = syn_out_q;
   assign bus.out_corrected     = corr_q;
   assign bus.out_uncorrectable = unc_q;
   assign bus.cnt_corrected     = cnt_corr_q;
   assign bus.cnt_uncorrectable = cnt_unc_q;
   assign bus.err_sticky        = sticky_q;
endmodule

// File: tb/tb_hamdec_secded_pipe.sv
// Directed bench for hamdec_secded_pipe: vector table, backpressure stream,
// counter saturation/clear on a 2-bit-counter instance, and mid-stream reset.
module tb_hamdec_secded_pipe;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   hamdec_secded_pipe_if #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) bus8 ();
   hamdec_secded_pipe_if #(.DATA_WIDTH(8), .COUNT_WIDTH(2))  bus2 ();

   hamdec_secded_pipe #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut8 (
      .clk(clk), .reset(reset), .bus(bus8)
   );
   hamdec_secded_pipe #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   typedef struct {
      logic [7:0] din;
      logic [4:0] edc;
      logic [7:0] dout;
      logic [3:0] syn;
      logic       corr;
      logic       unc;
   } vec_t;

   vec_t vecs [12];
   int   checks = 0;
   int   errors = 0;
   int   exp_cc = 0;
   int   exp_uc = 0;
   logic exp_sticky = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      int   sidx [4];
      int   exp_q [$];
      int   pushed;
      int   popped;
      logic held_valid;
      logic [7:0] held_data;
      logic [3:0] held_syn;
      logic held_corr, held_unc;

      vecs[0]  = '{8'hA5, 5'b00011, 8'hA5, 4'h0, 1'b0, 1'b0};
      vecs[1]  = '{8'hA1, 5'b00011, 8'hA5, 4'h6, 1'b1, 1'b0};
      vecs[2]  = '{8'hA6, 5'b00011, 8'hA6, 4'h6, 1'b0, 1'b1};
      vecs[3]  = '{8'hA5, 5'b10011, 8'hA5, 4'h0, 1'b1, 1'b0};
      vecs[4]  = '{8'hA5, 5'b00010, 8'hA5, 4'h1, 1'b1, 1'b0};
      vecs[5]  = '{8'h25, 5'b00000, 8'h25, 4'hF, 1'b0, 1'b1};
      vecs[6]  = '{8'h25, 5'b00011, 8'hA5, 4'hC, 1'b1, 1'b0};
      vecs[7]  = '{8'hA4, 5'b00011, 8'hA5, 4'h3, 1'b1, 1'b0};
      vecs[8]  = '{8'hFF, 5'b00011, 8'hFF, 4'h0, 1'b0, 1'b0};
      vecs[9]  = '{8'hFF, 5'b00000, 8'hFF, 4'h3, 1'b0, 1'b1};
      vecs[10] = '{8'h00, 5'b00000, 8'h00, 4'h0, 1'b0, 1'b0};
      vecs[11] = '{8'hA5, 5'b01011, 8'hA5, 4'h8, 1'b1, 1'b0};

      reset = 1'b1;
      bus8.data_in = '0; bus8.edc_in = '0; bus8.in_valid = 1'b0;
      bus8.out_ready = 1'b1; bus8.cnt_clear = 1'b0;
      bus2.data_in = '0; bus2.edc_in = '0; bus2.in_valid = 1'b0;
      bus2.out_ready = 1'b1; bus2.cnt_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
      chk("rst_data_out", 64'(bus8.data_out), 64'd0);
      chk("rst_flags", 64'({bus8.out_corrected, bus8.out_uncorrectable}), 64'd0);
      chk("rst_syndrome", 64'(bus8.out_syndrome), 64'd0);
      chk("rst_counters", 64'({bus8.cnt_corrected, bus8.cnt_uncorrectable}), 64'd0);
      chk("rst_sticky", 64'(bus8.err_sticky), 64'd0);
      chk("rst_in_ready", 64'(bus8.in_ready), 64'd1);

      // Table-driven single words: 2-clk latency, then counters after the handshake
      for (int i = 0; i < 12; i++) begin
         bus8.data_in  = vecs[i].din;
         bus8.edc_in   = vecs[i].edc;
         bus8.in_valid = 1'b1;
         @(posedge clk);
         #1 bus8.in_valid = 1'b0;
         @(posedge clk);
         #1;
         $display("vec %0d din=%h edc=%b -> dout=%h syn=%h corr=%0d unc=%0d",
                  i, vecs[i].din, vecs[i].edc, bus8.data_out, bus8.out_syndrome,
                  bus8.out_corrected, bus8.out_uncorrectable);
         chk($sformatf("vec%0d_valid", i), 64'(bus8.out_valid), 64'd1);
         chk($sformatf("vec%0d_data", i), 64'(bus8.data_out), 64'(vecs[i].dout));
         chk($sformatf("vec%0d_syn", i), 64'(bus8.out_syndrome), 64'(vecs[i].syn));
         chk($sformatf("vec%0d_corr", i), 64'(bus8.out_corrected), 64'(vecs[i].corr));
         chk($sformatf("vec%0d_unc", i), 64'(bus8.out_uncorrectable), 64'(vecs[i].unc));
         exp_cc += int'(vecs[i].corr);
         exp_uc += int'(vecs[i].unc);
         if (vecs[i].corr || vecs[i].unc) exp_sticky = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_cnt_corr", i), 64'(bus8.cnt_corrected), 64'(exp_cc));
         chk($sformatf("vec%0d_cnt_unc", i), 64'(bus8.cnt_uncorrectable), 64'(exp_uc));
         chk($sformatf("vec%0d_sticky", i), 64'(bus8.err_sticky), 64'(exp_sticky));
         chk($sformatf("vec%0d_bubble", i),
             64'({bus8.out_valid, bus8.out_corrected, bus8.out_uncorrectable}), 64'd0);
      end

      // Back-to-back stream of 4 words with a 3-cycle downstream stall
      sidx[0] = 0; sidx[1] = 8; sidx[2] = 10; sidx[3] = 5;
      pushed = 0; popped = 0; held_valid = 1'b0;
      held_data = '0; held_syn = '0; held_corr = 1'b0; held_unc = 1'b0;
      for (int cyc = 0; cyc < 40 && popped < 4; cyc++) begin
         bus8.out_ready = !(cyc >= 3 && cyc <= 5);
         bus8.in_valid  = (pushed < 4);
         if (pushed < 4) begin
            bus8.data_in = vecs[sidx[pushed]].din;
            bus8.edc_in  = vecs[sidx[pushed]].edc;
         end
         #1;
         if (bus8.out_valid && !bus8.out_ready) begin
            chk($sformatf("stall_in_ready_c%0d", cyc), 64'(bus8.in_ready), 64'd0);
            if (!held_valid) begin
               held_valid = 1'b1;
               held_data  = bus8.data_out;
               held_syn   = bus8.out_syndrome;
               held_corr  = bus8.out_corrected;
               held_unc   = bus8.out_uncorrectable;
            end else begin
               chk($sformatf("stall_hold_c%0d", cyc),
                   64'({bus8.data_out, bus8.out_syndrome, bus8.out_corrected, bus8.out_uncorrectable}),
                   64'({held_data, held_syn, held_corr, held_unc}));
            end
         end
         if (bus8.out_valid && bus8.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("stream_unexpected_word", 64'(bus8.data_out), 64'hDEAD);
            end else begin
               int e;
               e = exp_q.pop_front();
               $display("stream pop %0d dout=%h syn=%h corr=%0d unc=%0d",
                        popped, bus8.data_out, bus8.out_syndrome,
                        bus8.out_corrected, bus8.out_uncorrectable);
               chk($sformatf("stream%0d_data", popped), 64'(bus8.data_out), 64'(vecs[e].dout));
               chk($sformatf("stream%0d_syn", popped), 64'(bus8.out_syndrome), 64'(vecs[e].syn));
               chk($sformatf("stream%0d_flags", popped),
                   64'({bus8.out_corrected, bus8.out_uncorrectable}),
                   64'({vecs[e].corr, vecs[e].unc}));
               exp_cc += int'(vecs[e].corr);
               exp_uc += int'(vecs[e].unc);
               if (vecs[e].corr || vecs[e].unc) exp_sticky = 1'b1;
            end
            popped++;
            held_valid = 1'b0;
         end
         if (bus8.in_valid && bus8.in_ready) begin
            exp_q.push_back(sidx[pushed]);
            pushed++;
         end
         @(posedge clk);
         #1;
      end
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      chk("stream_words_out", 64'(popped), 64'd4);
      chk("stream_cnt_corr", 64'(bus8.cnt_corrected), 64'(exp_cc));
      chk("stream_cnt_unc", 64'(bus8.cnt_uncorrectable), 64'(exp_uc));

      // Saturation on the 2-bit counter instance: 5 corrected words
      for (int k = 0; k < 5; k++) begin
         bus2.data_in  = 8'hA1;
         bus2.edc_in   = 5'b00011;
         bus2.in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      bus2.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("sat cnt_corrected=%0d sticky=%0d", bus2.cnt_corrected, bus2.err_sticky);
      chk("sat_cnt_corr", 64'(bus2.cnt_corrected), 64'd3);
      chk("sat_cnt_unc", 64'(bus2.cnt_uncorrectable), 64'd0);
      chk("sat_sticky", 64'(bus2.err_sticky), 64'd1);

      // Clear collides with a corrected-word handshake: clear wins
      bus2.data_in  = 8'hA1;
      bus2.edc_in   = 5'b00011;
      bus2.in_valid = 1'b1;
      @(posedge clk);
      #1 bus2.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("clr_word_corr", 64'({bus2.out_valid, bus2.out_corrected}), 64'd3);
      bus2.cnt_clear = 1'b1;
      @(posedge clk);
      #1 bus2.cnt_clear = 1'b0;
      $display("clear cnt_corrected=%0d sticky=%0d", bus2.cnt_corrected, bus2.err_sticky);
      chk("clr_cnt_corr", 64'(bus2.cnt_corrected), 64'd0);
      chk("clr_sticky", 64'(bus2.err_sticky), 64'd0);

      // Counting resumes after a clear
      bus2.in_valid = 1'b1;
      @(posedge clk);
      #1 bus2.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post_clr_cnt_corr", 64'(bus2.cnt_corrected), 64'd1);
      chk("post_clr_sticky", 64'(bus2.err_sticky), 64'd1);

      // Reset with a word in flight: nothing emerges afterwards
      bus8.data_in  = 8'hA1;
      bus8.edc_in   = 5'b00011;
      bus8.in_valid = 1'b1;
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("midrst_counters", 64'({bus8.cnt_corrected, bus8.cnt_uncorrectable, bus8.err_sticky}), 64'd0);
      chk("midrst_in_ready", 64'(bus8.in_ready), 64'd1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("midrst_no_out_c%0d", k),
             64'({bus8.out_valid, bus8.out_corrected}), 64'd0);
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
